// File: rtl/hsv_pkg.sv
// Shared constants and FSM encoding for the HSV hue histogram block.
package hsv_pkg;

  localparam int          NUM_BINS = 12;
  localparam int          BIN_DEG  = 30;
  localparam logic [8:0]  HUE_MAX  = 9'd359;
  localparam logic [3:0]  LAST_BIN = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_e;

endpackage

// File: rtl/hue_bin_sel.sv
// Combinational hue-to-bin mapper: a comparator chain over the 30-degree bin edges.
module hue_bin_sel
  import hsv_pkg::*;
(
  input  logic [8:0] h_i,
  output logic [3:0] bin_o,
  output logic       in_range_o
);

  assign in_range_o = (h_i <= HUE_MAX);

  // Highest lower edge not exceeding h wins; out-of-range hues are flagged, not binned.
  always_comb begin
    bin_o = 4'd0;
    for (int k = 1; k < NUM_BINS; k++) begin
      if (h_i >= 9'(k * BIN_DEG)) bin_o = 4'(k);
    end
  end

endmodule

// File: rtl/hsv_hue_histogram.sv
// Per-frame 12-bin hue histogram of sufficiently saturated/bright pixels, dumped
// bin by bin over a valid/ready stream after the last pixel of each frame.
module hsv_hue_histogram
  import hsv_pkg::*;
#(
  parameter logic [7:0] S_MIN = 8'd20,
  parameter logic [7:0] V_MIN = 8'd20,
  parameter int         CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       h,
  input  logic [7:0]       s,
  input  logic [7:0]       v,
  input  logic             in_valid,
  input  logic             sof,
  input  logic             eof,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       bin_idx,
  output logic [CNT_W-1:0] bin_count,
  output logic             out_last,
  output logic [15:0]      drop_cnt,
  output state_e           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds its payload stable while valid=1 and ready=0.

  state_e           state_q;
  logic [3:0]       rd_idx_q;
  logic [15:0]      drop_q;
  logic [CNT_W-1:0] bins_q [NUM_BINS];

  logic [3:0]       sel_bin;
  logic             in_range;
  logic             accept;
  logic             pix_ok;
  logic             pix_drop;
  logic [CNT_W-1:0] bin_inc_d;
  logic [15:0]      drop_inc_d;

  hue_bin_sel u_sel (
    .h_i        (h),
    .bin_o      (sel_bin),
    .in_range_o (in_range)
  );

  assign accept   = in_valid && (state_q != DUMP);
  assign pix_ok   = in_range && (s >= S_MIN) && (v >= V_MIN);
  assign pix_drop = !in_range;

  always_comb begin
    bin_inc_d  = bins_q[sel_bin];
    drop_inc_d = drop_q;
    if (bins_q[sel_bin] != {CNT_W{1'b1}}) bin_inc_d = bins_q[sel_bin] + 1'b1;
    if (drop_q != 16'hFFFF) drop_inc_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rd_idx_q <= 4'd0;
      drop_q   <= 16'd0;
      for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept && (sof || state_q == ACCUM)) begin
            if (sof) begin
              // New frame: clear everything, then count this first pixel on top.
              for (int i = 0; i < NUM_BINS; i++) bins_q[i] <= '0;
              drop_q <= pix_drop ? 16'd1 : 16'd0;
              if (pix_ok) bins_q[sel_bin] <= CNT_W'(1);
            end else begin
              if (pix_ok)   bins_q[sel_bin] <= bin_inc_d;
              if (pix_drop) drop_q          <= drop_inc_d;
            end
            rd_idx_q <= 4'd0;
            state_q  <= eof ? DUMP : ACCUM;
          end
        end
        DUMP: begin
          if (out_ready) begin
            if (rd_idx_q == LAST_BIN) begin
              rd_idx_q <= 4'd0;
              state_q  <= IDLE;
            end else begin
              rd_idx_q <= rd_idx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q != DUMP);
  assign out_valid   = (state_q == DUMP);
  assign bin_idx     = out_valid ? rd_idx_q : 4'd0;
  assign bin_count   = out_valid ? bins_q[rd_idx_q] : '0;
  assign out_last    = out_valid && (rd_idx_q == LAST_BIN);
  assign drop_cnt    = drop_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hsv_hue_histogram.sv
// Directed bench for hsv_hue_histogram; a narrow-counter twin shares the stimulus
// so counter saturation can be observed in a handful of pixels.
module tb_hsv_hue_histogram;
  import hsv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  h = '0;
  logic [7:0]  s = '0;
  logic [7:0]  v = '0;
  logic        in_valid = 1'b0;
  logic        sof = 1'b0;
  logic        eof = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_last;
  logic [3:0]  bin_idx;
  logic [19:0] bin_count;
  logic [15:0] drop_cnt;
  state_e      dbg_state;

  logic        sat_in_ready, sat_out_valid, sat_out_last;
  logic [3:0]  sat_bin_idx;
  logic [1:0]  sat_bin_count;
  logic [15:0] sat_drop_cnt;
  state_e      sat_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [19:0] got_cnt  [12];
  logic [3:0]  got_idx  [12];
  logic        got_last [12];
  logic [1:0]  sat_bin0;
  int          n_got;
  int          v_cycles;
  logic [19:0] exp_q[$];

  hsv_hue_histogram dut (
    .clk(clk), .rst(rst), .h(h), .s(s), .v(v), .in_valid(in_valid), .sof(sof), .eof(eof),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .bin_idx(bin_idx),
    .bin_count(bin_count), .out_last(out_last), .drop_cnt(drop_cnt), .dbg_state_o(dbg_state)
  );

  hsv_hue_histogram #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .h(h), .s(s), .v(v), .in_valid(in_valid), .sof(sof), .eof(eof),
    .in_ready(sat_in_ready), .out_valid(sat_out_valid), .out_ready(out_ready),
    .bin_idx(sat_bin_idx), .bin_count(sat_bin_count), .out_last(sat_out_last),
    .drop_cnt(sat_drop_cnt), .dbg_state_o(sat_dbg_state)
  );

  // Clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic send_pix(input logic [8:0] ph, input logic [7:0] ps, input logic [7:0] pv,
                          input logic psof, input logic peof);
    h = ph; s = ps; v = pv; sof = psof; eof = peof; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic dump_all();
    n_got = 0; v_cycles = 0; sat_bin0 = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n_got < 12; c++) begin
      if (out_valid) v_cycles++;
      if (out_valid && out_ready) begin
        got_idx[n_got]  = bin_idx;
        got_cnt[n_got]  = bin_count;
        got_last[n_got] = out_last;
        if (bin_idx == 4'd0) sat_bin0 = sat_bin_count;
        n_got++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_hist(input int b0, input int c0, input int b1, input int c1,
                             input int b2, input int c2);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(20'd0);
    if (b0 >= 0) exp_q[b0] = 20'(c0);
    if (b1 >= 0) exp_q[b1] = 20'(c1);
    if (b2 >= 0) exp_q[b2] = 20'(c2);
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b exp 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b exp 0", out_last); else n_pass++;
    n_checks++; if (bin_idx !== 4'd0) $display("FAIL reset_bin_idx: got %0d exp 0", bin_idx); else n_pass++;
    n_checks++; if (bin_count !== 20'd0) $display("FAIL reset_bin_count: got %0d exp 0", bin_count); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d exp 0", drop_cnt); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    send_pix(9'd0,   8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd29,  8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd30,  8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd359, 8'd50, 8'd50, 1'b0, 1'b1);
    dump_all();
    expect_hist(0, 2, 1, 1, 11, 1);
    n_checks++; if (n_got !== 12) $display("FAIL basic_bins_seen: got %0d exp 12", n_got); else n_pass++;
    n_checks++; if (v_cycles !== 12) $display("FAIL basic_valid_cycles: got %0d exp 12", v_cycles); else n_pass++;
    for (int i = 0; i < n_got; i++) begin
      n_checks++; if (got_idx[i] !== 4'(i)) $display("FAIL basic_idx[%0d]: got %0d exp %0d", i, got_idx[i], i); else n_pass++;
      n_checks++; if (got_cnt[i] !== exp_q[i]) $display("FAIL basic_cnt[%0d]: got %0d exp %0d", i, got_cnt[i], exp_q[i]); else n_pass++;
      n_checks++; if (got_last[i] !== (i == 11)) $display("FAIL basic_last[%0d]: got %0b exp %0b", i, got_last[i], (i == 11)); else n_pass++;
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_post_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_post_ready: got %0b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_thresholds();
    send_pix(9'd200, 8'd50, 8'd50, 1'b0, 1'b0);  // no sof while idle: ignored
    send_pix(9'd100, 8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd100, 8'd19, 8'd50, 1'b0, 1'b0);
    send_pix(9'd100, 8'd50, 8'd19, 1'b0, 1'b0);
    send_pix(9'd100, 8'd20, 8'd20, 1'b0, 1'b1);
    dump_all();
    expect_hist(3, 2, -1, 0, -1, 0);
    n_checks++; if (n_got !== 12) $display("FAIL thresh_bins_seen: got %0d exp 12", n_got); else n_pass++;
    for (int i = 0; i < n_got; i++) begin
      n_checks++; if (got_cnt[i] !== exp_q[i]) $display("FAIL thresh_cnt[%0d]: got %0d exp %0d", i, got_cnt[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_drop();
    send_pix(9'd45,  8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd400, 8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd45,  8'd50, 8'd50, 1'b0, 1'b1);
    n_checks++; if (drop_cnt !== 16'd1) $display("FAIL drop_in_dump: got %0d exp 1", drop_cnt); else n_pass++;
    dump_all();
    expect_hist(1, 2, -1, 0, -1, 0);
    n_checks++; if (n_got !== 12) $display("FAIL drop_bins_seen: got %0d exp 12", n_got); else n_pass++;
    for (int i = 0; i < n_got; i++) begin
      n_checks++; if (got_cnt[i] !== exp_q[i]) $display("FAIL drop_cnt_bin[%0d]: got %0d exp %0d", i, got_cnt[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (drop_cnt !== 16'd1) $display("FAIL drop_after_dump: got %0d exp 1", drop_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    int nh;
    send_pix(9'd330, 8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd150, 8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd150, 8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd210, 8'd50, 8'd50, 1'b0, 1'b1);
    expect_hist(11, 1, 5, 2, 7, 1);
    nh = 0;
    for (int c = 0; c < 60 && nh < 12; c++) begin
      out_ready = c[0];
      h = 9'd0; s = 8'd50; v = 8'd50; sof = 1'b1; eof = 1'b1; in_valid = 1'b1;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid c=%0d: got %0b exp 1", c, out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready c=%0d: got %0b exp 0", c, in_ready); else n_pass++;
      n_checks++; if (bin_idx !== 4'(nh)) $display("FAIL stall_idx c=%0d: got %0d exp %0d", c, bin_idx, nh); else n_pass++;
      n_checks++; if (bin_count !== exp_q[nh]) $display("FAIL stall_cnt c=%0d: got %0d exp %0d", c, bin_count, exp_q[nh]); else n_pass++;
      if (out_ready) nh++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; sof = 1'b0; eof = 1'b0; out_ready = 1'b1;
    n_checks++; if (nh !== 12) $display("FAIL stall_handshakes: got %0d exp 12", nh); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL stall_end_state: got %0d exp %0d", dbg_state, IDLE); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_end_valid: got %0b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_restart();
    send_pix(9'd60, 8'd50, 8'd50, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_pix(9'd75, 8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd120, 8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd130, 8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd149, 8'd50, 8'd50, 1'b0, 1'b1);
    dump_all();
    expect_hist(4, 3, -1, 0, -1, 0);
    n_checks++; if (n_got !== 12) $display("FAIL restart_bins_seen: got %0d exp 12", n_got); else n_pass++;
    for (int i = 0; i < n_got; i++) begin
      n_checks++; if (got_cnt[i] !== exp_q[i]) $display("FAIL restart_cnt[%0d]: got %0d exp %0d", i, got_cnt[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_saturation();
    send_pix(9'd0, 8'd50, 8'd50, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_pix(9'd5, 8'd50, 8'd50, 1'b0, 1'b0);
    send_pix(9'd10, 8'd50, 8'd50, 1'b0, 1'b1);
    dump_all();
    n_checks++; if (got_cnt[0] !== 20'd5) $display("FAIL sat_wide_bin0: got %0d exp 5", got_cnt[0]); else n_pass++;
    n_checks++; if (sat_bin0 !== 2'd3) $display("FAIL sat_narrow_bin0: got %0d exp 3", sat_bin0); else n_pass++;
  endtask

  task automatic test_one_pixel();
    send_pix(9'd359, 8'd100, 8'd100, 1'b1, 1'b1);
    n_checks++; if (dbg_state !== DUMP) $display("FAIL onepix_state: got %0d exp %0d", dbg_state, DUMP); else n_pass++;
    dump_all();
    expect_hist(11, 1, -1, 0, -1, 0);
    n_checks++; if (n_got !== 12) $display("FAIL onepix_bins_seen: got %0d exp 12", n_got); else n_pass++;
    for (int i = 0; i < n_got; i++) begin
      n_checks++; if (got_cnt[i] !== exp_q[i]) $display("FAIL onepix_cnt[%0d]: got %0d exp %0d", i, got_cnt[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_in_dump();
    send_pix(9'd10, 8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd10, 8'd50, 8'd50, 1'b0, 1'b1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (bin_idx !== 4'd5) $display("FAIL rstdump_idx_before: got %0d exp 5", bin_idx); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstdump_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstdump_in_ready: got %0b exp 1", in_ready); else n_pass++;
    n_checks++; if (bin_idx !== 4'd0) $display("FAIL rstdump_idx_after: got %0d exp 0", bin_idx); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    send_pix(9'd300, 8'd50, 8'd50, 1'b1, 1'b0);
    send_pix(9'd300, 8'd50, 8'd50, 1'b0, 1'b1);
    dump_all();
    expect_hist(10, 2, -1, 0, -1, 0);
    n_checks++; if (n_got !== 12) $display("FAIL rstdump_bins_seen: got %0d exp 12", n_got); else n_pass++;
    for (int i = 0; i < n_got; i++) begin
      n_checks++; if (got_cnt[i] !== exp_q[i]) $display("FAIL rstdump_cnt[%0d]: got %0d exp %0d", i, got_cnt[i], exp_q[i]); else n_pass++;
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic_frame();
    test_thresholds();
    test_drop();
    test_stall();
    test_restart();
    test_saturation();
    test_one_pixel();
    test_reset_in_dump();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
